motor_move_arb: RTL and testbench



---
 rtl/motor_pkg.sv | 18 +
 rtl/motor_rr_pick.sv | 36 +++
 rtl/motor_move_arb.sv | 197 +++++++++++++++++++
 tb/tb_motor_move_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared constants for the motor move arbiter: state encodings, direction values, state width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package motor_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ARB_IDLE  = 3'd0,
        ARB_MOVE  = 3'd1,
        ARB_DWELL = 3'd2,
        ARB_FAULT = 3'd3
    } arb_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/motor_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot, index and any-valid.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module motor_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0] pos;

    // Walk the requesters starting at ptr and keep the first one that is set.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        pos  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                idx                = pos[IW-1:0];
                pick[pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_move_arb.sv
// Shares one up/down motor between NREQ requesters; round-robin grant, travel watchdog, post-move dwell.
// Latency: grant and motor drive appear 1 cycle after the pick; done/fault pulse on the edge the move ends.
// Backpressure: requests are levels held until done/fault; new grants wait for IDLE. Optional fault_cnt via MOTOR_MOVE_ARB_FAULT_CNT_EN.
module motor_move_arb
    import motor_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int DWELL   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_dir,
    input  logic               up_limit,
    input  logic               dn_limit,
    input  logic               clear_fault,
    output logic [NREQ-1:0]    gnt,
    output logic               motor_up,
    output logic               motor_dn,
    output logic               done,
    output logic               fault,
    output logic               busy,
`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
    output logic [7:0]         fault_cnt,
`endif
    output logic [STATE_W-1:0] arb_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state, state_n;
    logic [NREQ-1:0]   gnt_n;
    logic              up_n, dn_n, done_n, fault_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [IW-1:0]     gidx, gidx_n;
    logic              dir, dir_n;
    logic [TMO_W-1:0]  cnt, cnt_n;
    logic [7:0]        dcnt, dcnt_n;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              pick_dir;
    logic              pick_at_target;
    logic              at_target;

    // Pointer moves one past whoever just held the motor.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    motor_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign pick_dir       = req_dir[pick_idx];
    assign pick_at_target = (pick_dir == DIR_UP) ? up_limit : dn_limit;
    assign at_target      = (dir == DIR_UP) ? up_limit : dn_limit;

    assign busy      = (state != ARB_IDLE);
    assign arb_state = state;

    // Next-state and next-output decode; every exit from a move drops the motor in the same edge.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        up_n    = motor_up;
        dn_n    = motor_dn;
        done_n  = 1'b0;
        fault_n = 1'b0;
        ptr_n   = ptr;
        gidx_n  = gidx;
        dir_n   = dir;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        case (state)
            ARB_IDLE: begin
                gnt_n = '0;
                up_n  = 1'b0;
                dn_n  = 1'b0;
                if (pick_any) begin
                    gidx_n = pick_idx;
                    dir_n  = pick_dir;
                    cnt_n  = '0;
                    if (pick_at_target) begin
                        // Already where it wants to be: finish without driving.
                        done_n  = 1'b1;
                        ptr_n   = next_ptr(pick_idx);
                        dcnt_n  = '0;
                        state_n = ARB_DWELL;
                    end else begin
                        gnt_n   = pick_oh;
                        up_n    = (pick_dir == DIR_UP);
                        dn_n    = (pick_dir == DIR_DN);
                        state_n = ARB_MOVE;
                    end
                end
            end
            ARB_MOVE: begin
                if ((up_limit && dn_limit) || !req[gidx] || at_target ||
                    (cnt == TMO_W'(TIMEOUT - 1))) begin
                    gnt_n  = '0;
                    up_n   = 1'b0;
                    dn_n   = 1'b0;
                    ptr_n  = next_ptr(gidx);
                    dcnt_n = '0;
                    if (up_limit && dn_limit) begin
                        fault_n = 1'b1;
                        state_n = ARB_FAULT;
                    end else if (!req[gidx]) begin
                        state_n = ARB_DWELL;
                    end else if (at_target) begin
                        done_n  = 1'b1;
                        state_n = ARB_DWELL;
                    end else begin
                        fault_n = 1'b1;
                        state_n = ARB_FAULT;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ARB_DWELL: begin
                gnt_n = '0;
                up_n  = 1'b0;
                dn_n  = 1'b0;
                if (dcnt == 8'(DWELL - 1)) begin
                    state_n = ARB_IDLE;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            ARB_FAULT: begin
                gnt_n = '0;
                up_n  = 1'b0;
                dn_n  = 1'b0;
                if (clear_fault) begin
                    dcnt_n  = '0;
                    state_n = ARB_DWELL;
                end
            end
            default: begin
                gnt_n   = '0;
                up_n    = 1'b0;
                dn_n    = 1'b0;
                state_n = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the motor asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            motor_up <= 1'b0;
            motor_dn <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            ptr      <= '0;
            gidx     <= '0;
            dir      <= DIR_DN;
            cnt      <= '0;
            dcnt     <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            motor_up <= up_n;
            motor_dn <= dn_n;
            done     <= done_n;
            fault    <= fault_n;
            ptr      <= ptr_n;
            gidx     <= gidx_n;
            dir      <= dir_n;
            cnt      <= cnt_n;
            dcnt     <= dcnt_n;
        end
    end

`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
    // Saturating count of fault pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt <= '0;
        end else if (fault && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_motor_move_arb.sv
// Directed bench for motor_move_arb with NREQ=4, TIMEOUT=20, DWELL=8.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_motor_move_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req_dir;
    logic       up_limit;
    logic       dn_limit;
    logic       clear_fault;
    logic [3:0] gnt;
    logic       motor_up;
    logic       motor_dn;
    logic       done;
    logic       fault;
    logic       busy;
    logic [2:0] arb_state;
`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    motor_move_arb #(.NREQ(4), .TMO_W(16), .TIMEOUT(20), .DWELL(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_dir     (req_dir),
        .up_limit    (up_limit),
        .dn_limit    (dn_limit),
        .clear_fault (clear_fault),
        .gnt         (gnt),
        .motor_up    (motor_up),
        .motor_dn    (motor_dn),
        .done        (done),
        .fault       (fault),
        .busy        (busy),
`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
        .fault_cnt   (fault_cnt),
`endif
        .arb_state   (arb_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant; n is the number of edges waited.
    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt == 4'b0000 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // From the first DWELL sample: 7 more busy cycles, then IDLE.
    task automatic dwell_out(input string tag);
        repeat (7) tick();
        chk({tag, "_dwell_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_idle"}, {29'd0, arb_state}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_dir = '0;
        up_limit = 1'b0; dn_limit = 1'b0; clear_fault = 1'b0;
        repeat (2) tick();
        chk("rst_state", {29'd0, arb_state}, 32'd0);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_motor", {30'd0, motor_up, motor_dn}, 32'd0);
        chk("rst_pulses", {30'd0, done, fault}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single up move, limit after 5 motor cycles.
        req = 4'b0010; req_dir = 4'b0010;
        tick();
        chk("t1_gnt", {28'd0, gnt}, 32'h2);
        chk("t1_state_move", {29'd0, arb_state}, 32'd1);
        chk("t1_motor_up", {30'd0, motor_up, motor_dn}, 32'd2);
        n = 1;
        repeat (4) begin
            tick();
            if (motor_up) n++;
        end
        up_limit = 1'b1;
        tick();
        chk("t1_motor_cycles", n, 32'd5);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_motor_off", {30'd0, motor_up, motor_dn}, 32'd0);
        chk("t1_state_dwell", {29'd0, arb_state}, 32'd2);
        req = '0; up_limit = 1'b0;
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        repeat (6) tick();
        chk("t1_dwell_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_idle", {29'd0, arb_state}, 32'd0);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);

        // 2: all four requesting, round robin 0,1,2,3,0 from a fresh pointer.
        rst_n = 1'b0; req = 4'b1111; req_dir = 4'b1111;
        #3;
        rst_n = 1'b1;
        tick();
        chk("t2_gnt0", {28'd0, gnt}, 32'h1);
        for (int k = 1; k < 5; k++) begin
            up_limit = 1'b1;
            tick();
            chk("t2_done", {31'd0, done}, 32'd1);
            up_limit = 1'b0;
            wait_gnt(n);
            chk("t2_gap", n, 32'd9);
            chk("t2_gnt", {28'd0, gnt}, 32'(1 << (k % 4)));
        end
        up_limit = 1'b1;
        tick();
        chk("t2_done_last", {31'd0, done}, 32'd1);
        up_limit = 1'b0;

        // 3: down move with no limit -> timeout after exactly 20 drive cycles.
        req = 4'b0100; req_dir = 4'b0000;
        wait_gnt(n);
        chk("t3_gnt", {28'd0, gnt}, 32'h4);
        chk("t3_motor_dn", {30'd0, motor_up, motor_dn}, 32'd1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!motor_dn) break;
            n++;
        end
        chk("t3_motor_cycles", n, 32'd20);
        chk("t3_fault", {31'd0, fault}, 32'd1);
        chk("t3_state_fault", {29'd0, arb_state}, 32'd3);
        req = 4'b0001; req_dir = 4'b0000;
        repeat (5) tick();
        chk("t3_ignored_gnt", {28'd0, gnt}, 32'd0);
        chk("t3_still_fault", {29'd0, arb_state}, 32'd3);
        chk("t3_fault_pulse", {31'd0, fault}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        req = '0; clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("t3_dwell", {29'd0, arb_state}, 32'd2);
        dwell_out("t3");

        // 4: target limit already active at pick -> immediate done, no drive.
        req = 4'b0001; req_dir = 4'b0001; up_limit = 1'b1;
        tick();
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_no_motor", {30'd0, motor_up, motor_dn}, 32'd0);
        chk("t4_dwell", {29'd0, arb_state}, 32'd2);
        req = '0; up_limit = 1'b0;
        dwell_out("t4");

        // 5a: abort by dropping the granted request at cycle 3.
        req = 4'b0010; req_dir = 4'b0010;
        tick();
        chk("t5_gnt", {28'd0, gnt}, 32'h2);
        repeat (2) tick();
        req = '0;
        tick();
        chk("t5_motor_off", {30'd0, motor_up, motor_dn}, 32'd0);
        chk("t5_gnt_off", {28'd0, gnt}, 32'd0);
        chk("t5_no_done", {30'd0, done, fault}, 32'd0);
        chk("t5_dwell", {29'd0, arb_state}, 32'd2);
        dwell_out("t5a");

        // 5b: both limits high during a move -> fault.
        req = 4'b0100; req_dir = 4'b0100;
        tick();
        chk("t5_gnt2", {28'd0, gnt}, 32'h4);
        up_limit = 1'b1; dn_limit = 1'b1;
        tick();
        chk("t5_conflict_fault", {31'd0, fault}, 32'd1);
        chk("t5_conflict_done", {31'd0, done}, 32'd0);
        chk("t5_conflict_state", {29'd0, arb_state}, 32'd3);
        chk("t5_conflict_motor", {30'd0, motor_up, motor_dn}, 32'd0);
        up_limit = 1'b0; dn_limit = 1'b0; req = '0; clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        dwell_out("t5b");
`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
        chk("fault_cnt", {24'd0, fault_cnt}, 32'd2);
`endif

        // 6: asynchronous reset mid-move; pointer returns to 0.
        req = 4'b0010; req_dir = 4'b0000;
        tick();
        chk("t6_gnt", {28'd0, gnt}, 32'h2);
        chk("t6_motor_dn", {30'd0, motor_up, motor_dn}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_motor", {30'd0, motor_up, motor_dn}, 32'd0);
        chk("t6_async_gnt", {28'd0, gnt}, 32'd0);
        chk("t6_async_state", {29'd0, arb_state}, 32'd0);
`ifdef MOTOR_MOVE_ARB_FAULT_CNT_EN
        chk("fault_cnt_rst", {24'd0, fault_cnt}, 32'd0);
`endif
        req = 4'b1111; req_dir = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_ptr_zero", {28'd0, gnt}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
